// File: rtl/instr_encoder.sv
// Encodes operation descriptors into 32-bit instruction words and streams them to instruction memory through a 4-deep FIFO.
// Optional feature: define INSTR_ENCODER_SWP_EN to make op_sel 18 (SWP) legal.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        dest,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  input  logic [15:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [5:0]  opc;
  logic        rtype, legal;
  logic [4:0]  d_f, s1_f, s2_f;
  logic [31:0] enc_word;

  always_comb begin
    opc   = 6'h00;
    rtype = 1'b1;
    legal = 1'b1;
    d_f   = dest;
    s1_f  = src1;
    s2_f  = src2;
    case (op_sel)
      5'd0:  begin d_f = '0; s1_f = '0; s2_f = '0; end
      5'd1:  opc = 6'h01;
      5'd2:  opc = 6'h03;
      5'd3:  opc = 6'h05;
      5'd4:  opc = 6'h06;
      5'd5:  opc = 6'h07;
      5'd6:  opc = 6'h08;
      5'd7:  opc = 6'h09;
      5'd8:  opc = 6'h0A;
      5'd9:  opc = 6'h0B;
      5'd10: opc = 6'h0C;
      5'd11: begin opc = 6'h20; rtype = 1'b0; end
      5'd12: begin opc = 6'h21; rtype = 1'b0; end
      5'd13: begin opc = 6'h24; rtype = 1'b0; end
      5'd14: begin opc = 6'h25; rtype = 1'b0; end
      5'd15: begin opc = 6'h28; rtype = 1'b0; d_f = '0; end
      5'd16: begin opc = 6'h29; rtype = 1'b0; end
      5'd17: begin opc = 6'h2A; rtype = 1'b0; d_f = '0; s1_f = '0; end
`ifdef INSTR_ENCODER_SWP_EN
      5'd18: begin opc = 6'h3F; s2_f = '0; end
`else
      5'd18: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
  end

  // NOP (op 0) keeps opc and every field at zero, so it falls out as an all-zero R-type word.
  assign enc_word = {opc, d_f, s1_f, rtype ? {s2_f, 11'b0} : imm};

  logic [3:0][31:0]  mem_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ww_q, ww_d;
  logic              err_q;
  logic              accept, push, pop;

  assign in_ready = (cnt_q < 3'd4);
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal & ~restart;
  assign imem_we  = (cnt_q != 3'd0);
  assign pop      = imem_we & imem_ready & ~restart;

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    ww_d   = ww_q;
    if (restart) begin
      cnt_d  = '0;
      addr_d = BASE;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
      if (pop) begin
        addr_d = addr_q + ADDR_W'(4);
        if (ww_q != 16'hFFFF) ww_d = ww_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE;
      ww_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      ww_q   <= ww_d;
      err_q  <= accept & ~legal;
      if (restart) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= enc_word;
          wr_ptr_q        <= wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  // Empty FIFO presents zero rather than a stale entry.
  assign imem_wdata    = imem_we ? mem_q[rd_ptr_q] : 32'h0;
  assign imem_addr     = addr_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential instruction encoder and program writer: the inverse of the core's opcode decoder.
- Accepts one operation descriptor per handshake (operation select, register fields, immediate) and encodes it into the 32-bit instruction word the decoder consumes.
- Buffers encoded words in a 4-entry FIFO and writes them into instruction memory at an auto-incrementing byte address.
- Sits between the test/boot loader and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 8, width of the instruction-memory byte address
- BASE_ADDR, 0, first write address after reset/restart (multiple of 4)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- restart  in  1  synchronous: empty FIFO, address := BASE_ADDR
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- op_sel  in  5  operation index (see Operation)
- dest  in  5  destination / second-operand register
- src1  in  5  first source register
- src2  in  5  second source register
- imm  in  16  immediate
- imem_we  out  1  write strobe
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  byte address of the current write
- imem_wdata  out  32  encoded instruction
- err  out  1  one-cycle pulse: illegal op_sel dropped
- words_written  out  16  count of completed memory writes

## Operation
- Word layout: opcode[31:26], dest[25:21], src1[20:16], then src2[15:11] with [10:0]=0 (R-type) or imm[15:0] (I-type).
- op_sel → opcode:
  - R-type: 0 NOP=00, 1 ADD=01, 2 SUB=03, 3 AND=05, 4 OR=06, 5 NOR=07, 6 XOR=08, 7 SLA=09, 8 SLL=0A, 9 SRA=0B, 10 SRL=0C.
  - I-type: 11 ADDI=20, 12 SUBI=21, 13 LD=24, 14 ST=25, 15 BEZ=28, 16 BNE=29, 17 JMP=2A.
  - Special: 18 SWP=3F (R-type, src2 field zero).
- Field zeroing:
  - NOP: whole word zero.
  - BEZ: dest=0.
  - JMP: dest=0, src1=0.
  - ST and BNE: value / second compare register carried in dest.
- op_sel ≥ 19, or illegal per Configuration:
  - Handshake still completes.
  - Nothing is pushed.
  - err=1 on the next cycle.
- FIFO:
  - Depth 4, count 0..4.
  - in_ready = (count<4). A push is refused at full even if a pop occurs in the same cycle.
  - Simultaneous push and pop with 0<count<4: count unchanged.
- Write side:
  - imem_we = (count>0). imem_wdata and imem_addr present the FIFO head.
  - A write completes when imem_we & imem_ready: pop the head, imem_addr += 4, words_written += 1.
  - imem_addr wraps modulo 2^ADDR_W.
  - words_written saturates at 0xFFFF.
- restart:
  - Overrides a same-cycle push and pop. The pending head is not written.
  - words_written is not cleared.
- Reset values: count=0, in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, err=0, words_written=0.
- Reset mid-transfer: discards all FIFO contents immediately.

## Timing
- Encoding is combinational on the inputs; the encoded word is registered into the FIFO at the accepting edge.
- Descriptor accepted at edge N → imem_we=1 with that word from cycle N+1; no bubbles with back-to-back input and imem_ready held high.
- Throughput: one word per cycle.
- Address and count update at the completing edge.
- err is registered: asserted during the cycle after the accepting edge, for exactly one cycle.
- imem_ready low holds imem_addr and imem_wdata stable while imem_we=1.

## Configuration
- INSTR_ENCODER_SWP_EN defined: op_sel 18 encodes SWP (opcode 0x3F).
- Not defined: op_sel 18 is illegal (dropped, err pulse); all other behaviour identical.

## Test plan
- Reset, ADD dest=3 src1=1 src2=2, imem_ready=1 → next cycle imem_we=1, wdata=0x04611000, addr=0x00; then addr=0x04, words_written=1.
- ADDI dest=5 imm=0xFFFF, then JMP imm=0x0010 back-to-back → wdata 0x80A0FFFF at addr 0x00, then 0xA8000010 at 0x04; no idle cycle.
- imem_ready=0, push 5 descriptors → 4 accepted, in_ready=0 on 5th; imem_ready=1 → 4 writes in order, then in_ready=1.
- ADDR_W=8, write 64 words → 64th at 0xFC, next write at 0x00.
- op_sel=25 → err pulses once, no write; with INSTR_ENCODER_SWP_EN, op_sel=18 dest=1 src1=2 → 0xFC220000; without it, err pulse and no write.
- FIFO holding 3 words, assert restart (or rst low) → imem_we=0 next cycle, addr=BASE_ADDR, in_ready=1.
